// File: rtl/labelled_regfile.sv
// labelled_regfile
// ----------------
// DEPTH x WIDTH register file in which every entry carries a 1-bit security
// label (0 = L, 1 = H). The file supports:
//   - writes that replace data and label together,
//   - single-entry downgrade (label to L, data zeroised),
//   - label-checked reads with one cycle of latency,
//   - a background scrub that zeroises every H entry.
//
// Optional build macro: LBL_RF_DENY_CNT_EN adds a saturating deny_cnt output.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   wr_en/wr_addr/wr_lbl/wr_data   write request (accepted when wr_ready)
//   wr_ready          write/clear accepted this cycle (low while scrubbing)
//   clr_en/clr_addr   downgrade-and-zeroise request (accepted when wr_ready)
//   rd_en/rd_addr/rd_lbl           read request with reader clearance
//   rd_data/rd_valid/rd_denied     registered read response
//   scrub_req         start a scrub of all H entries
//   scrub_busy        scrub in progress (exactly DEPTH cycles)
//   scrub_done        one-cycle pulse after the last entry is scrubbed
//   deny_cnt          (LBL_RF_DENY_CNT_EN only) saturating count of denials
module labelled_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             wr_lbl,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic             rd_lbl,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_denied,
  input  logic             scrub_req,
  output logic             scrub_busy,
  output logic             scrub_done
`ifdef LBL_RF_DENY_CNT_EN
  ,
  output logic [CW-1:0]    deny_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] lbl;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [AW-1:0]    idx;
  logic             rd_lbl_q;
  logic             deny_now;

  assign scrub_busy = (state == S_SCAN);
  assign scrub_done = (state == S_DONE);
  assign wr_ready   = !scrub_busy;

  // A read is refused when the entry label is above the reader clearance.
  assign deny_now   = lbl[rd_addr] & ~rd_lbl;

  // NOTE: every output of a combinational block gets a default assignment
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (scrub_req) state_nxt = S_SCAN;
      S_SCAN:  if (idx == AW'(DEPTH - 1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; this gives read-before-write for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && scrub_req) idx <= '0;
      else if (scrub_busy)              idx <= idx + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately resettable: a reset must leave
  // no H data behind, so each entry is a flop with a synchronous clear
  // rather than an inferred RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      lbl <= '0;
    end else if (scrub_busy) begin
      // Only H entries are touched; L entries survive the scrub.
      if (lbl[idx]) begin
        mem[idx] <= '0;
        lbl[idx] <= 1'b0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
        lbl[wr_addr] <= wr_lbl;
      end
      // Placed after the write so a same-address clear overrides it.
      if (clr_en) begin
        mem[clr_addr] <= '0;
        lbl[clr_addr] <= 1'b0;
      end
    end
  end

  // Registered read port; rd_data is zero whenever the read is not granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_denied <= 1'b0;
      rd_lbl_q  <= 1'b0;
    end else begin
      rd_valid  <= rd_en;
      rd_denied <= rd_en & deny_now;
      rd_data   <= (rd_en && !deny_now) ? mem[rd_addr] : '0;
      if (rd_en) rd_lbl_q <= rd_lbl;
    end
  end

`ifdef LBL_RF_DENY_CNT_EN
  // Counts alongside rd_denied (same edge), saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst)                                   deny_cnt <= '0;
    else if (rd_en && deny_now && deny_cnt != '1) deny_cnt <= deny_cnt + 1'b1;
  end
`endif

endmodule
